// File: rtl/cla_multiword_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit limb per cycle through a single shared CLA16,
// least-significant limb first, with the inter-limb carry rebuilt from the group G/P outputs.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        g,
  output logic        p
);
  logic [15:0] gb, pb, c;
  logic [3:0]  gg, pg, gc;

  always_comb begin
    gb = a & b;
    pb = a ^ b;
    for (int j = 0; j < 4; j++) begin
      gg[j] = gb[4*j+3] | (pb[4*j+3] & gb[4*j+2]) | (pb[4*j+3] & pb[4*j+2] & gb[4*j+1]) |
              (pb[4*j+3] & pb[4*j+2] & pb[4*j+1] & gb[4*j]);
      pg[j] = &pb[4*j +: 4];
    end
    // Second-level lookahead: carry into each 4-bit group straight from cin.
    gc[0] = cin;
    gc[1] = gg[0] | (pg[0] & cin);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
    g     = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]);
    p     = &pg;
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = gb[4*j] | (pb[4*j] & gc[j]);
      c[4*j+2] = gb[4*j+1] | (pb[4*j+1] & gb[4*j]) | (pb[4*j+1] & pb[4*j] & gc[j]);
      c[4*j+3] = gb[4*j+2] | (pb[4*j+2] & gb[4*j+1]) | (pb[4*j+2] & pb[4*j+1] & gb[4*j]) |
                 (pb[4*j+2] & pb[4*j+1] & pb[4*j] & gc[j]);
    end
    sum = pb ^ c;
  end
endmodule

module cla_multiword_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);
  localparam int unsigned W    = 16 * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [W-1:0]      op_a_q, op_b_q, sum_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q, cout_q, ovf_q;
  logic [IdxW+3:0]   base;
  logic [15:0]       limb_sum;
  logic              limb_g, limb_p, carry_next, last;

  assign base       = {idx_q, 4'h0};
  assign carry_next = limb_g | (limb_p & carry_q);
  assign last       = (idx_q == IdxW'(WORDS - 1));

  cla16 u_cla16 (
    .a   (op_a_q[base +: 16]),
    .b   (op_b_q[base +: 16]),
    .cin (carry_q),
    .sum (limb_sum),
    .g   (limb_g),
    .p   (limb_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_a_q  <= a;
            // Subtract as A + ~B + 1: invert B here, inject the +1 as the initial carry.
            op_b_q  <= b ^ {W{sub}};
            carry_q <= sub;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[base +: 16] <= limb_sum;
          carry_q           <= carry_next;
          if (last) begin
            cout_q  <= carry_next;
            ovf_q   <= (op_a_q[W-1] == op_b_q[W-1]) && (limb_sum[15] != op_a_q[W-1]);
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Scoreboard bench for cla_multiword_seq: driver pushes model results, negedge monitor pops and
// compares on each result handshake.

module tb_cla_multiword_seq;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 0;
  bit   prev_hold = 0;
  res_t prev_res;

  cla_multiword_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer add/subtract on wide vectors, overflow from the true signed result.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t                 r;
    logic [W:0]           u;
    logic signed [W+1:0]  sx, sy, ideal;
    u     = s ? ({1'b0, x} + {1'b0, ~y} + (W+1)'(1)) : ({1'b0, x} + {1'b0, y});
    sx    = signed'({{2{x[W-1]}}, x});
    sy    = signed'({{2{y[W-1]}}, y});
    ideal = s ? (sx - sy) : (sx + sy);
    r.sum  = u[W-1:0];
    r.cout = u[W];
    r.ovf  = ideal[W] ^ ideal[W-1];
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor: result handshake completes at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_vec++;
        if (!out_valid || ({sum, cout, ovf} !== prev_res)) begin
          n_err++;
          $display("FAIL hold_stable: got v=%b %h/%b/%b expected v=1 %h/%b/%b", out_valid, sum,
                   cout, ovf, prev_res.sum, prev_res.cout, prev_res.ovf);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %h with empty scoreboard", sum);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", W'(cout), W'(e.cout));
          chk("ovf", W'(ovf), W'(e.ovf));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_res  = {sum, cout, ovf};
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    for (int i = 0; i < 200 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1");
    end
    a        = x;
    b        = y;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(model(x, y, s));
  endtask

  // Called right after the acceptance edge; checks RUN length and in_ready isolation.
  task automatic check_latency();
    for (int k = 1; k <= WORDS; k++) begin
      @(posedge clk);
      #1;
      chk("in_ready_low", W'(in_ready), W'(0));
      if (k < WORDS) chk("run_busy_valid", W'({busy, out_valid}), W'(2'b10));
      else           chk("out_valid_rise", W'({busy, out_valid}), W'(2'b11));
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    issue(x, y, s);
    check_latency();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && !(in_ready && exp_q.size() == 0); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_idle", W'({in_ready, busy}), W'(2'b10));
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    logic [W-1:0] specials [4];
    specials[0] = '0;
    specials[1] = '1;
    specials[2] = {1'b0, {(W-1){1'b1}}};
    specials[3] = {1'b1, {(W-1){1'b0}}};
    v = {$urandom, $urandom};
    if ($urandom_range(0, 4) == 0) v = specials[$urandom_range(0, 3)];
    return v;
  endfunction

  logic [W-1:0] dir_a [7];
  logic [W-1:0] dir_b [7];
  logic         dir_s [7];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_ctrl", W'({in_ready, out_valid, busy}), W'(3'b100));
    chk("reset_sum", sum, '0);
    chk("reset_flags", W'({cout, ovf}), W'(0));

    dir_a[0] = 64'h0000_0000_0000_FFFF; dir_b[0] = 64'h1; dir_s[0] = 1'b0;
    dir_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; dir_b[1] = 64'h1; dir_s[1] = 1'b0;
    dir_a[2] = 64'h7FFF_FFFF_FFFF_FFFF; dir_b[2] = 64'h1; dir_s[2] = 1'b0;
    dir_a[3] = 64'h5;                   dir_b[3] = 64'h3; dir_s[3] = 1'b1;
    dir_a[4] = 64'h3;                   dir_b[4] = 64'h5; dir_s[4] = 1'b1;
    dir_a[5] = 64'h8000_0000_0000_0000; dir_b[5] = 64'h1; dir_s[5] = 1'b1;
    dir_a[6] = 64'h1234_5678_9ABC_DEF0; dir_b[6] = 64'h0; dir_s[6] = 1'b1;
    for (int i = 0; i < 7; i++) do_op(dir_a[i], dir_b[i], dir_s[i]);
    wait_idle();

    // Input isolation: operands and in_valid churn during RUN must not matter.
    issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
    a        = rand_word();
    b        = rand_word();
    sub      = 1'b1;
    in_valid = 1'b1;
    check_latency();
    in_valid = 1'b0;
    wait_idle();

    // Backpressure: hold DONE for three cycles, then release.
    out_ready = 1'b0;
    do_op(64'hDEAD_BEEF_0000_0001, 64'h1111_2222_3333_4444, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_hold_ctrl", W'({in_ready, out_valid, busy}), W'(3'b011));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", W'({in_ready, out_valid, busy}), W'(3'b100));

    // Abort: reset at acceptance+2 discards the operation.
    issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    chk("abort_ctrl", W'({in_ready, out_valid, busy}), W'(3'b100));
    chk("abort_sum", sum, '0);
    chk("abort_flags", W'({cout, ovf}), W'(0));
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", W'(out_valid), W'(0));
    end
    do_op(64'h2, 64'h3, 1'b0);
    wait_idle();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) do_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)));
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("scoreboard_empty", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
